// File: rtl/branch_redirect_ctrl.sv
// Branch resolution in EX with a 2-bit BHT predictor, a handshaked PC redirect and a timed IF/ID flush.
// Redirect is registered one cycle after a mispredict and held until redirect_ready; ex_* is ignored while busy.
module branch_redirect_ctrl #(
  parameter int BHT_ENTRIES  = 16,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        if_pred_taken,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_is_jump,
  input  logic        ex_bsel,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        flush_if,
  output logic        flush_id,
  output logic [15:0] br_count,
  output logic [15:0] mispred_count
);
  localparam int IDX = $clog2(BHT_ENTRIES);
  localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_REDIRECT, S_FLUSH} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_redirect_valid, w_redirect_valid_nxt;
  logic [31:0] r_redirect_pc, w_redirect_pc_nxt;
  logic        r_flush, w_flush_nxt;
  logic [1:0]  r_bht [BHT_ENTRIES];
  logic [15:0] r_br_count, r_mispred_count;

  logic           w_resolve, w_mispredict, w_bht_upd;
  logic [31:0]    w_correct_pc;
  logic [IDX-1:0] w_if_idx, w_ex_idx;
  logic           w_unused_pc_bits;

  assign w_if_idx = if_pc[IDX+1:2];
  assign w_ex_idx = ex_pc[IDX+1:2];
  assign w_unused_pc_bits = ^{if_pc[31:IDX+2], if_pc[1:0]};

  // A branch flagged as a jump too is treated purely as a jump.
  assign w_resolve    = ex_valid & (ex_is_branch | ex_is_jump) & (r_state == S_IDLE);
  assign w_mispredict = w_resolve & (ex_is_jump ? ~ex_pred_taken : (ex_bsel != ex_pred_taken));
  assign w_bht_upd    = w_resolve & ex_is_branch & ~ex_is_jump;
  assign w_correct_pc = (ex_is_jump | ex_bsel) ? ex_target : ex_pc + 32'd4;

  assign if_pred_taken  = r_bht[w_if_idx][1];
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign flush_if       = r_flush;
  assign flush_id       = r_flush;
  assign br_count       = r_br_count;
  assign mispred_count  = r_mispred_count;

  always_comb begin
    w_state_nxt          = r_state;
    w_cnt_nxt            = r_cnt;
    w_redirect_valid_nxt = r_redirect_valid;
    w_redirect_pc_nxt    = r_redirect_pc;
    w_flush_nxt          = r_flush;
    case (r_state)
      S_IDLE: begin
        if (w_mispredict) begin
          w_state_nxt          = S_REDIRECT;
          w_redirect_valid_nxt = 1'b1;
          w_redirect_pc_nxt    = w_correct_pc;
          w_flush_nxt          = 1'b1;
        end
      end
      S_REDIRECT: begin
        if (r_redirect_valid && redirect_ready) begin
          w_redirect_valid_nxt = 1'b0;
          if (FLUSH_CYCLES == 0) begin
            w_state_nxt = S_IDLE;
            w_flush_nxt = 1'b0;
          end else begin
            w_state_nxt = S_FLUSH;
            w_cnt_nxt   = FLUSH_LOAD;
          end
        end
      end
      S_FLUSH: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_IDLE;
          w_flush_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt          = S_IDLE;
        w_redirect_valid_nxt = 1'b0;
        w_flush_nxt          = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_cnt            <= 4'd0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= 32'd0;
      r_flush          <= 1'b0;
      r_br_count       <= 16'd0;
      r_mispred_count  <= 16'd0;
      for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= 2'b01;
    end else begin
      r_state          <= w_state_nxt;
      r_cnt            <= w_cnt_nxt;
      r_redirect_valid <= w_redirect_valid_nxt;
      r_redirect_pc    <= w_redirect_pc_nxt;
      r_flush          <= w_flush_nxt;
      if (w_resolve && r_br_count != 16'hFFFF) r_br_count <= r_br_count + 16'd1;
      if (w_mispredict && r_mispred_count != 16'hFFFF) r_mispred_count <= r_mispred_count + 16'd1;
      // Saturating 2-bit counter; same-cycle lookups see the old value.
      if (w_bht_upd) begin
        if (ex_bsel) begin
          if (r_bht[w_ex_idx] != 2'b11) r_bht[w_ex_idx] <= r_bht[w_ex_idx] + 2'b01;
        end else begin
          if (r_bht[w_ex_idx] != 2'b00) r_bht[w_ex_idx] <= r_bht[w_ex_idx] - 2'b01;
        end
      end
    end
  end
endmodule
